// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target, oversampled in the clk domain.
// Ports:
//   clk, reset           system clock, async active-high reset
//   sck, cs, sdi         SPI inputs from the master (asynchronous)
//   sdo, sdo_oe          target-out data and its pad enable
//   rx_data, rx_valid    received byte and one-cycle update pulse
//   tx_data, tx_valid,   transmit holding register write port
//   tx_ready
//   underrun, frame_err  one-cycle event pulses
//   busy                 high while a frame is active
`timescale 1ns/1ps
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       underrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronizer chains; cs idles high so its chain resets to 1
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_d;
    logic                   cs_d;

    logic sck_s;
    logic cs_s;
    logic sdi_s;
    logic rise;
    logic fall;
    logic cs_fall;
    logic cs_rise;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   rx_shift, rx_shift_n;
    logic [DATA_W-1:0]   tx_shift, tx_shift_n;
    logic [DATA_W-1:0]   hold, hold_n;
    logic [DATA_W-1:0]   rx_data_n;
    logic                rx_valid_n;
    logic                tx_ready_n;
    logic                underrun_n;
    logic                frame_err_n;
    logic                load;

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign sdi_s   = sdi_sync[SYNC_STAGES-1];
    assign rise    = sck_s & ~sck_d;
    assign fall    = ~sck_s & sck_d;
    assign cs_fall = ~cs_s & cs_d;
    assign cs_rise = cs_s & ~cs_d;

    // Input synchronization and edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
        end
    end

    // Next-state, datapath and event logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rx_shift_n  = rx_shift;
        tx_shift_n  = tx_shift;
        hold_n      = hold;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        tx_ready_n  = tx_ready;
        underrun_n  = 1'b0;
        frame_err_n = 1'b0;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = ACTIVE;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                // cs_rise wins over a coincident sck edge
                if (cs_rise) begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    rx_shift_n = '0;
                    if (cnt != CNT_W'(0)) begin
                        frame_err_n = 1'b1;
                    end
                end else if (rise) begin
                    rx_shift_n = {rx_shift[DATA_W-2:0], sdi_s};
                    cnt_n      = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        rx_data_n  = {rx_shift[DATA_W-2:0], sdi_s};
                        rx_valid_n = 1'b1;
                    end
                end else if (fall) begin
                    if (cnt == CNT_W'(0)) begin
                        load = 1'b1;
                    end else begin
                        tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Load sees the register state before any same-cycle write
        if (load) begin
            if (!tx_ready) begin
                tx_shift_n = hold;
                tx_ready_n = 1'b1;
            end else begin
                tx_shift_n = IDLE_BYTE;
                underrun_n = 1'b1;
            end
        end

        if (tx_valid && tx_ready) begin
            hold_n     = tx_data;
            tx_ready_n = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold      <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b1;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            sdo_oe    <= 1'b0;
            sdo       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rx_shift  <= rx_shift_n;
            tx_shift  <= tx_shift_n;
            hold      <= hold_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            tx_ready  <= tx_ready_n;
            underrun  <= underrun_n;
            frame_err <= frame_err_n;
            busy      <= (state_n == ACTIVE);
            sdo_oe    <= (state_n == ACTIVE);
            sdo       <= tx_shift_n[DATA_W-1];
        end
    end

endmodule
